// File: rtl/mc_wait_controller_pkg.sv
// Shared definitions for the multi-cycle accumulator-machine controller:
// opcode values, ALU command encoding and the controller state enum.
package mc_pkg;

  localparam int ALU_W = 3;

  // Opcodes live in the low four bits of IR part 0.
  localparam logic [3:0] OP_LDA = 4'd0;
  localparam logic [3:0] OP_STA = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_NOT = 4'd5;
  localparam logic [3:0] OP_JMP = 4'd6;
  localparam logic [3:0] OP_JZ  = 4'd7;
  localparam logic [3:0] OP_JC  = 4'd8;
  localparam logic [3:0] OP_JN  = 4'd9;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [ALU_W-1:0] ALU_ADD    = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB    = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND    = 3'b010;
  localparam logic [ALU_W-1:0] ALU_NOT    = 3'b011;
  localparam logic [ALU_W-1:0] ALU_PASS_B = 3'b100;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    RDMEM,
    EXEC,
    WRMEM,
    HALT,
    ERR
  } state_t;

  // States in which a memory strobe is up and the wait timer may run.
  function automatic logic is_mem_phase(input state_t s);
    return (s == FETCH) || (s == RDMEM) || (s == WRMEM);
  endfunction

endpackage

// File: rtl/mc_wait_controller_if.sv
// Controller <-> datapath/memory bundle. The controller takes the master
// side; the datapath and memory take the slave side.
interface mc_wait_controller_if
  import mc_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int IR_PARTS = 2,
  parameter int CNT_W    = 16
);

  logic [OPW-1:0]      upcode;
  logic                c_flag;
  logic                z_flag;
  logic                n_flag;
  logic                mem_ready;

  logic                pc_write;
  logic                pc_data_sel;
  logic                mem_address_sel;
  logic                mem_read;
  logic                mem_write;
  logic [IR_PARTS-1:0] ir_write;
  logic                data_reg_en;
  logic                ac_write;
  logic [ALU_W-1:0]    alu_command;
  logic                c_en;
  logic                z_en;
  logic                n_en;
  logic                halted;
  logic                error;
  logic [CNT_W-1:0]    instr_count;

  modport master (
    input  upcode, c_flag, z_flag, n_flag, mem_ready,
    output pc_write, pc_data_sel, mem_address_sel, mem_read, mem_write,
           ir_write, data_reg_en, ac_write, alu_command, c_en, z_en, n_en,
           halted, error, instr_count
  );

  modport slave (
    output upcode, c_flag, z_flag, n_flag, mem_ready,
    input  pc_write, pc_data_sel, mem_address_sel, mem_read, mem_write,
           ir_write, data_reg_en, ac_write, alu_command, c_en, z_en, n_en,
           halted, error, instr_count
  );

endinterface

// File: rtl/mc_wait_controller_timer.sv
// Wait timer: counts consecutive stalled cycles of one memory access and
// flags a timeout on the MAX_WAIT-th stalled cycle.
module mc_wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count,
  output logic timeout
);

  localparam int TW = $clog2(MAX_WAIT + 1);

  logic [TW-1:0] cnt;

  // Stall counter; clear has priority so a ready beat restarts the window.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count) begin
      cnt <= cnt + TW'(1);
    end
  end

  // Fires while the stall that would bring the count to MAX_WAIT is happening.
  assign timeout = count && (cnt == TW'(MAX_WAIT - 1));

endmodule

// File: rtl/mc_wait_controller.sv
// Multi-cycle accumulator-machine controller with an IR_PARTS-beat fetch,
// mem_ready stalls, wait-timeout error state and a retired-instruction
// counter. Opcode is decoded from the low four bits of upcode (OPW >= 4);
// any set bit above those makes the opcode undefined.
module mc_wait_controller
  import mc_pkg::*;
#(
  parameter int OPW      = 4,
  parameter int IR_PARTS = 2,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  mc_wait_controller_if.master  bus
);

  localparam int              KW     = (IR_PARTS > 1) ? $clog2(IR_PARTS) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(IR_PARTS - 1);

  state_t           state;
  state_t           state_next;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_next;
  logic [CNT_W-1:0] instr_count;
  logic             retire;

  logic [3:0]       op;
  logic             op_hi_clear;
  logic             jump_taken;
  logic             wait_count;
  logic             wait_clear;
  logic             wait_timeout;

  assign op          = bus.upcode[3:0];
  assign op_hi_clear = ((bus.upcode >> 4) == '0);
  assign jump_taken  = (op == OP_JMP)
                    || ((op == OP_JZ) && bus.z_flag)
                    || ((op == OP_JC) && bus.c_flag)
                    || ((op == OP_JN) && bus.n_flag);

  // Timer runs only while a strobe is up and memory has not answered; any
  // other cycle (ready beat, non-memory state) clears it, which also covers
  // clearing on entry to each memory state.
  assign wait_count = is_mem_phase(state) && !bus.mem_ready;
  assign wait_clear = !wait_count;

  mc_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .count   (wait_count),
    .timeout (wait_timeout)
  );

  // State, fetch-part index and retired-instruction counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FETCH;
      k           <= '0;
      instr_count <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (retire) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  assign bus.instr_count = instr_count;

  // Next-state and strobe decode; everything is held at 0 while rst is high.
  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next          = state;
    k_next              = k;
    retire              = 1'b0;
    bus.pc_write        = 1'b0;
    bus.pc_data_sel     = 1'b0;
    bus.mem_address_sel = 1'b0;
    bus.mem_read        = 1'b0;
    bus.mem_write       = 1'b0;
    bus.ir_write        = '0;
    bus.data_reg_en     = 1'b0;
    bus.ac_write        = 1'b0;
    bus.alu_command     = ALU_ADD;
    bus.c_en            = 1'b0;
    bus.z_en            = 1'b0;
    bus.n_en            = 1'b0;
    bus.halted          = 1'b0;
    bus.error           = 1'b0;

    if (!rst) begin
      case (state)
        FETCH: begin
          bus.mem_read = 1'b1;
          if (bus.mem_ready) begin
            bus.ir_write = IR_PARTS'(1) << k;
            bus.pc_write = 1'b1;
            if (k == K_LAST) begin
              k_next     = '0;
              state_next = DECODE;
            end else begin
              k_next = k + KW'(1);
            end
          end else if (wait_timeout) begin
            state_next = ERR;
          end
        end

        DECODE: begin
          if (!op_hi_clear) begin
            state_next = ERR;
          end else begin
            case (op)
              OP_LDA, OP_ADD, OP_SUB, OP_AND: state_next = RDMEM;
              OP_STA:                         state_next = WRMEM;
              OP_NOT:                         state_next = EXEC;
              OP_JMP, OP_JZ, OP_JC, OP_JN: begin
                bus.pc_write    = jump_taken;
                bus.pc_data_sel = jump_taken;
                state_next      = FETCH;
                retire          = 1'b1;
              end
              OP_HLT: begin
                state_next = HALT;
                retire     = 1'b1;
              end
              default: state_next = ERR;
            endcase
          end
        end

        RDMEM: begin
          bus.mem_read        = 1'b1;
          bus.mem_address_sel = 1'b1;
          if (bus.mem_ready) begin
            bus.data_reg_en = 1'b1;
            state_next      = EXEC;
          end else if (wait_timeout) begin
            state_next = ERR;
          end
        end

        EXEC: begin
          bus.ac_write = 1'b1;
          state_next   = FETCH;
          retire       = 1'b1;
          case (op)
            OP_LDA: begin
              bus.alu_command = ALU_PASS_B;
              bus.z_en        = 1'b1;
              bus.n_en        = 1'b1;
            end
            OP_ADD: begin
              bus.alu_command = ALU_ADD;
              bus.c_en        = 1'b1;
              bus.z_en        = 1'b1;
              bus.n_en        = 1'b1;
            end
            OP_SUB: begin
              bus.alu_command = ALU_SUB;
              bus.c_en        = 1'b1;
              bus.z_en        = 1'b1;
              bus.n_en        = 1'b1;
            end
            OP_AND: begin
              bus.alu_command = ALU_AND;
              bus.z_en        = 1'b1;
              bus.n_en        = 1'b1;
            end
            OP_NOT: begin
              bus.alu_command = ALU_NOT;
              bus.z_en        = 1'b1;
              bus.n_en        = 1'b1;
            end
            default: ;
          endcase
        end

        WRMEM: begin
          bus.mem_write       = 1'b1;
          bus.mem_address_sel = 1'b1;
          if (bus.mem_ready) begin
            state_next = FETCH;
            retire     = 1'b1;
          end else if (wait_timeout) begin
            state_next = ERR;
          end
        end

        HALT: bus.halted = 1'b1;

        ERR: bus.error = 1'b1;

        default: state_next = ERR;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_wait_controller.sv
// Directed bench: a table of single instructions run back to back with
// zero-wait memory, plus hand-written sequences for stalls, timeout,
// undefined opcode with a three-part IR, and reset during a fetch.
module tb_mc_wait_controller;
  import mc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  mc_wait_controller_if #(.OPW(4), .IR_PARTS(2), .CNT_W(16)) bus_a ();
  mc_wait_controller_if #(.OPW(4), .IR_PARTS(3), .CNT_W(16)) bus_b ();

  mc_wait_controller #(.OPW(4), .IR_PARTS(2), .MAX_WAIT(4), .CNT_W(16)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mc_wait_controller #(.OPW(4), .IR_PARTS(3), .MAX_WAIT(15), .CNT_W(16)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  typedef struct {
    logic [3:0] op;
    logic       z;
    logic       c;
    logic       n;
    int         lat;
    logic [2:0] alu;
    logic [2:0] en;   // {c_en, z_en, n_en} seen with ac_write
    int         drd;
    int         acw;
    int         mw;
    int         jmp;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit into cycle 1 (first cycle after rst falls).
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int         fetch_n, seq_n, jmp_n, drd_n, acw_n, mw_n, rd_n, drd_cyc, strobe_n;
  logic [2:0] alu_cap, en_or;
  int         exp_cnt;

  initial begin
    vecs[0]  = '{OP_LDA, 1'b0, 1'b0, 1'b0, 5, ALU_PASS_B, 3'b011, 1, 1, 0, 0};
    vecs[1]  = '{OP_ADD, 1'b0, 1'b0, 1'b0, 5, ALU_ADD,    3'b111, 1, 1, 0, 0};
    vecs[2]  = '{OP_SUB, 1'b0, 1'b0, 1'b0, 5, ALU_SUB,    3'b111, 1, 1, 0, 0};
    vecs[3]  = '{OP_AND, 1'b0, 1'b0, 1'b0, 5, ALU_AND,    3'b011, 1, 1, 0, 0};
    vecs[4]  = '{OP_NOT, 1'b0, 1'b0, 1'b0, 4, ALU_NOT,    3'b011, 0, 1, 0, 0};
    vecs[5]  = '{OP_STA, 1'b0, 1'b0, 1'b0, 4, 3'b000,     3'b000, 0, 0, 1, 0};
    vecs[6]  = '{OP_JMP, 1'b0, 1'b0, 1'b0, 3, 3'b000,     3'b000, 0, 0, 0, 1};
    vecs[7]  = '{OP_JZ,  1'b1, 1'b0, 1'b0, 3, 3'b000,     3'b000, 0, 0, 0, 1};
    vecs[8]  = '{OP_JZ,  1'b0, 1'b1, 1'b1, 3, 3'b000,     3'b000, 0, 0, 0, 0};
    vecs[9]  = '{OP_JC,  1'b0, 1'b1, 1'b0, 3, 3'b000,     3'b000, 0, 0, 0, 1};
    vecs[10] = '{OP_JN,  1'b1, 1'b1, 1'b0, 3, 3'b000,     3'b000, 0, 0, 0, 0};
    vecs[11] = '{OP_JN,  1'b0, 1'b0, 1'b1, 3, 3'b000,     3'b000, 0, 0, 0, 1};
    vecs[12] = '{OP_JC,  1'b1, 1'b0, 1'b1, 3, 3'b000,     3'b000, 0, 0, 0, 0};

    bus_a.upcode = OP_LDA; bus_a.mem_ready = 1'b1;
    bus_a.c_flag = 1'b0;   bus_a.z_flag = 1'b0; bus_a.n_flag = 1'b0;
    bus_b.upcode = 4'd12;  bus_b.mem_ready = 1'b1;
    bus_b.c_flag = 1'b0;   bus_b.z_flag = 1'b0; bus_b.n_flag = 1'b0;

    // Reset state: all strobes and status low while rst is high.
    @(negedge clk);
    check("rst_mem_read", bus_a.mem_read, 1'b0);
    check("rst_ir_write", bus_a.ir_write, 2'b00);
    check("rst_status", {bus_a.halted, bus_a.error}, 2'b00);
    check("rst_count", bus_a.instr_count, 16'd0);

    // Program LDA, ADD, HLT with zero-wait memory.
    do_reset();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      if (cyc == 6)  bus_a.upcode = OP_ADD;
      if (cyc == 11) bus_a.upcode = OP_HLT;
      @(negedge clk);
      if (cyc == 1) begin
        check("prog_first_read", {bus_a.mem_read, bus_a.mem_address_sel}, 2'b10);
        check("prog_irw_c1", bus_a.ir_write, 2'b01);
      end
      if (cyc == 2)  check("prog_irw_c2", bus_a.ir_write, 2'b10);
      if (cyc == 13) check("prog_not_halted_c13", bus_a.halted, 1'b0);
      if (cyc == 14) check("prog_halted_c14", bus_a.halted, 1'b1);
      if (cyc < 14) next_cycle();
    end
    check("prog_count", bus_a.instr_count, 16'd3);
    check("prog_halt_strobes", {bus_a.mem_read, bus_a.mem_write, bus_a.pc_write}, 3'b000);
    repeat (3) next_cycle();
    @(negedge clk);
    check("prog_halt_sticky", {bus_a.halted, bus_a.error}, 2'b10);
    check("prog_count_held", bus_a.instr_count, 16'd3);

    // Table: one instruction per vector, back to back.
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < NV; i++) begin
      bus_a.upcode = vecs[i].op;
      bus_a.z_flag = vecs[i].z;
      bus_a.c_flag = vecs[i].c;
      bus_a.n_flag = vecs[i].n;
      fetch_n = 0; seq_n = 0; jmp_n = 0; drd_n = 0; acw_n = 0; mw_n = 0;
      alu_cap = 3'b000; en_or = 3'b000;
      for (int c = 0; c < vecs[i].lat; c++) begin
        @(negedge clk);
        if (bus_a.mem_read && !bus_a.mem_address_sel) fetch_n++;
        if (bus_a.pc_write && !bus_a.pc_data_sel) seq_n++;
        if (bus_a.pc_write && bus_a.pc_data_sel) jmp_n++;
        if (bus_a.data_reg_en) drd_n++;
        if (bus_a.mem_write) mw_n++;
        if (bus_a.ac_write) begin
          acw_n++;
          alu_cap = bus_a.alu_command;
        end
        en_or = en_or | {bus_a.c_en, bus_a.z_en, bus_a.n_en};
        next_cycle();
      end
      exp_cnt++;
      check($sformatf("v%0d_fetch", i), fetch_n, 2);
      check($sformatf("v%0d_seq_pc", i), seq_n, 2);
      check($sformatf("v%0d_jump", i), jmp_n, vecs[i].jmp);
      check($sformatf("v%0d_data_reg_en", i), drd_n, vecs[i].drd);
      check($sformatf("v%0d_ac_write", i), acw_n, vecs[i].acw);
      check($sformatf("v%0d_mem_write", i), mw_n, vecs[i].mw);
      check($sformatf("v%0d_alu", i), alu_cap, vecs[i].alu);
      check($sformatf("v%0d_flag_en", i), en_or, vecs[i].en);
      check($sformatf("v%0d_count", i), bus_a.instr_count, exp_cnt);
      check($sformatf("v%0d_next_fetch", i),
            {bus_a.mem_read, bus_a.mem_address_sel, bus_a.ir_write}, 4'b1001);
    end

    // ADD with mem_ready low for 3 cycles in RDMEM (cycles 4..6).
    bus_a.upcode = OP_ADD;
    bus_a.z_flag = 1'b0; bus_a.c_flag = 1'b0; bus_a.n_flag = 1'b0;
    bus_a.mem_ready = 1'b1;
    do_reset();
    rd_n = 0; drd_n = 0; drd_cyc = 0;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      bus_a.mem_ready = !(cyc >= 4 && cyc <= 6);
      @(negedge clk);
      if (bus_a.mem_read && bus_a.mem_address_sel) rd_n++;
      if (bus_a.data_reg_en) begin
        drd_n++;
        drd_cyc = cyc;
      end
      if (cyc < 9) next_cycle();
    end
    check("stall_rd_cycles", rd_n, 4);
    check("stall_drd_pulses", drd_n, 1);
    check("stall_drd_cycle", drd_cyc, 7);
    check("stall_count", bus_a.instr_count, 16'd1);
    check("stall_back_fetch", {bus_a.mem_read, bus_a.mem_address_sel, bus_a.error}, 3'b100);

    // STA with mem_ready stuck low in WRMEM, MAX_WAIT=4.
    bus_a.upcode = OP_STA;
    bus_a.mem_ready = 1'b1;
    do_reset();
    mw_n = 0; strobe_n = 0;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      if (cyc == 4) bus_a.mem_ready = 1'b0;
      if (cyc == 9) bus_a.mem_ready = 1'b1;
      @(negedge clk);
      if (bus_a.mem_write) mw_n++;
      if (cyc >= 8 && (bus_a.mem_read || bus_a.mem_write || bus_a.pc_write ||
                       bus_a.ir_write != 2'b00 || bus_a.data_reg_en)) strobe_n++;
      if (cyc == 7) check("tmo_c7", {bus_a.error, bus_a.mem_write}, 2'b01);
      if (cyc == 8) check("tmo_c8", {bus_a.error, bus_a.mem_write}, 2'b10);
      if (cyc < 10) next_cycle();
    end
    check("tmo_write_cycles", mw_n, 4);
    check("tmo_err_strobes", strobe_n, 0);
    check("tmo_err_sticky", {bus_a.error, bus_a.halted}, 2'b10);
    check("tmo_count", bus_a.instr_count, 16'd0);
    do_reset();
    @(negedge clk);
    check("tmo_rst_clears", {bus_a.error, bus_a.mem_read}, 2'b01);

    // Reset mid-fetch at k=1.
    bus_a.upcode = OP_LDA;
    bus_a.mem_ready = 1'b1;
    do_reset();
    @(negedge clk);
    check("mid_rst_irw_c1", bus_a.ir_write, 2'b01);
    next_cycle();
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", {bus_a.mem_read, bus_a.pc_write, bus_a.ir_write}, 4'b0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_refetch", bus_a.ir_write, 2'b01);
    check("mid_rst_count", bus_a.instr_count, 16'd0);

    // IR_PARTS=3 instance with undefined opcode 12.
    bus_b.upcode = 4'd12;
    bus_b.mem_ready = 1'b1;
    do_reset();
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (cyc == 1) check("undef_irw_c1", bus_b.ir_write, 3'b001);
      if (cyc == 2) check("undef_irw_c2", bus_b.ir_write, 3'b010);
      if (cyc == 3) check("undef_irw_c3", bus_b.ir_write, 3'b100);
      if (cyc == 4) check("undef_decode_no_err", bus_b.error, 1'b0);
      if (cyc < 5) next_cycle();
    end
    check("undef_error", {bus_b.error, bus_b.mem_read}, 2'b10);
    check("undef_count", bus_b.instr_count, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_wait_controller.md
# mc_wait_controller

Parametrised multi-cycle accumulator-machine controller. It is the successor to the fixed two-part, fixed-latency controller. It fetches an instruction in IR_PARTS memory beats and stalls on a mem_ready handshake for variable-latency memory. A wait-timeout drives an error state, and a retired-instruction counter is exposed. It sits beside the datapath, drives its strobes/selects and reads back opcode and flags.

## Interface
- OPW, 4: opcode width (opcode taken from IR part 0).
- IR_PARTS, 2: memory beats per instruction fetch, ≥1.
- MAX_WAIT, 15: max consecutive cycles mem_ready may stay low in one access, ≥1.
- CNT_W, 16: retired-instruction counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- upcode  in  OPW  opcode from IR part 0.
- c_flag, z_flag, n_flag  in  1 each  datapath flags.
- mem_ready  in  1  memory completes current read/write this cycle.
- pc_write, pc_data_sel  out  1  PC load; select 0=PC+1, 1=IR target.
- mem_address_sel  out  1  0=PC, 1=IR address field.
- mem_read, mem_write  out  1  memory strobes, held until mem_ready.
- ir_write  out  IR_PARTS  one-hot IR part load.
- data_reg_en, ac_write  out  1  data register / accumulator load.
- alu_command  out  3  ALU op.
- c_en, z_en, n_en  out  1  flag loads.
- halted, error  out  1  sticky status.
- instr_count  out  CNT_W  retired instructions, wraps.

## Operation
- States: FETCH, DECODE, RDMEM, EXEC, WRMEM, HALT, ERR. Part index k counts 0..IR_PARTS-1.
- Opcodes: 0 LDA, 1 STA, 2 ADD, 3 SUB, 4 AND, 5 NOT, 6 JMP, 7 JZ, 8 JC, 9 JN, 15 HLT. All others are undefined.
- ALU ops: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PASS_B.
- FETCH:
  - Assert mem_read with mem_address_sel=0.
  - When mem_ready is high, assert ir_write[k] and pc_write (pc_data_sel=0).
  - If k=last, go to DECODE with k←0; otherwise k←k+1.
- DECODE:
  - LDA/ADD/SUB/AND go to RDMEM.
  - STA goes to WRMEM.
  - NOT goes to EXEC.
  - JMP: pc_write=1, pc_data_sel=1, go to FETCH, retire.
  - JZ/JC/JN: same as JMP when z/c/n is set; otherwise go to FETCH with no PC write, retire.
  - HLT goes to HALT, retire.
  - Undefined opcode goes to ERR.
- RDMEM: mem_read=1, mem_address_sel=1. When mem_ready is high, assert data_reg_en and go to EXEC.
- EXEC: ac_write=1, then go to FETCH and retire.
  - LDA: PASS_B, z_en, n_en.
  - ADD/SUB: c_en, z_en, n_en.
  - AND/NOT: z_en, n_en.
- WRMEM: mem_write=1, mem_address_sel=1. When mem_ready is high, go to FETCH and retire.
- Wait timer:
  - Cleared on entry to FETCH/RDMEM/WRMEM and on every mem_ready.
  - Increments each cycle the strobe is up and mem_ready is low.
  - When it reaches MAX_WAIT with mem_ready still low, go to ERR and drop the strobe.
- HALT and ERR are absorbing until rst. In them all strobes are 0 and halted/error=1.
- Retire increments instr_count mod 2^CNT_W.

## Timing
- Strobes are Moore outputs decoded from state/k, plus mem_ready qualification for the ir_write/pc_write/data_reg_en beat.
- Reset forces:
  - state=FETCH, k=0, timer=0, instr_count=0, halted=error=0.
  - All strobes 0 while rst is high.
- First mem_read occurs in the first cycle after rst falls.
- Zero-wait latency (mem_ready tied 1) per instruction:
  - IR_PARTS fetch cycles plus DECODE.
  - Plus 2 for LDA/ADD/SUB/AND.
  - Plus 1 for NOT/STA.
  - Plus 0 for jumps.
- Each low mem_ready cycle adds one cycle to the latency.
- A mem_ready pulse outside FETCH/RDMEM/WRMEM is ignored.
- Reset mid-access aborts immediately. A partly loaded IR is not cleared; the refetch overwrites it.

## Structure
- Shared package mc_pkg holds:
  - Opcode localparams.
  - ALU command encoding.
  - State enum.
- Sub-module mc_wait_timer: clear/count inputs, timeout output, MAX_WAIT parameter.

## Test plan
- IR_PARTS=2, mem_ready=1, program LDA, ADD, HLT:
  - ir_write goes 01, 10 on consecutive cycles.
  - HLT is reached at cycle 14.
  - instr_count=3, halted=1.
- mem_ready low for 3 cycles during the RDMEM of ADD: mem_read is held 4 cycles, and data_reg_en pulses exactly once on the ready cycle.
- JZ with z_flag=1: pc_write with pc_data_sel=1 in DECODE. With z_flag=0: no pc_write, next cycle is FETCH.
- MAX_WAIT=4 with mem_ready stuck 0 in WRMEM: error rises on the 5th cycle, mem_write drops, and the block stays in ERR until rst.
- IR_PARTS=3, upcode=12 (undefined): 3 fetch beats, then error=1, and instr_count is unchanged.
- rst asserted mid-fetch at k=1: outputs 0 in the same cycle; after release, ir_write[0] is loaded first, instr_count=0.
